normalize_seq: RTL and testbench
================================

Name: normalize_seq

Overview:
Parametrised, multi-cycle successor to the combinational normalizer.
- Left-shifts an unnormalised mantissa until its MSB (bit MAN_W-1) is set, decrementing the exponent by the same amount.
- Shifts at most STEP bits per cycle; never lets the exponent go below 0.
- Sits between the add/sub datapath and the rounding stage, with valid/ready handshakes on both sides.
- Adds zero and denormal flags plus a shift-count output that the old block lacks.

Parameters:
- EXP_W, 8: exponent width.
- MAN_W, 26: mantissa width; the normalised position is bit MAN_W-1.
- STEP, 4: maximum left shift per cycle; legal range 1..MAN_W.
- SH_W, $clog2(MAN_W)+1: width of the shift_total output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- exp_in  in  EXP_W  input exponent (unsigned).
- mantis_in  in  MAN_W  input mantissa.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- exp_out  out  EXP_W  normalised exponent.
- mantis_out  out  MAN_W  normalised mantissa.
- shift_total  out  SH_W  total left shift applied.
- zero  out  1  input mantissa was 0.
- denorm  out  1  exponent clamped at 0 before MSB reached.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears all registers. Outputs after reset: in_ready=1, out_valid=0, exp_out=0, mantis_out=0, shift_total=0, zero=0, denorm=0. Reset mid-operation discards the operand; no output is produced.
- FSM states: IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - in_valid && in_ready: latch m=mantis_in, e=exp_in; clear shift_total, zero, denorm; go to BUSY.
  - Otherwise hold.
- BUSY, evaluated once per cycle:
  - If m==0: exp_out=0, mantis_out=0, zero=1; go to DONE.
  - Else:
    - lz = leading zeros of m, counted from bit MAN_W-1.
    - s = min(lz, STEP, e).
    - Update m <<= s, e -= s, shift_total += s.
    - If s==STEP, stay in BUSY. Otherwise go to DONE.
    - On going to DONE: denorm=1 iff the shifted m has bit MAN_W-1 == 0.
- Latency:
  - Non-clamped operand: BUSY occupies floor(lz/STEP)+1 cycles. out_valid rises that many cycles after the accept edge.
  - Normalised input (lz=0): 1 BUSY cycle.
  - Zero mantissa: 1 BUSY cycle.
- DONE:
  - Outputs hold stable while out_valid && !out_ready.
  - On out_ready: go to IDLE. in_ready returns the next cycle; no same-cycle accept.
- Arithmetic:
  - All shifts are logical left shifts with zeros filled in.
  - e never underflows: an exponent of 0 on entry gives s=0, so the operand passes through in 1 BUSY cycle with the denorm rule applied.
  - shift_total equals exp_in - exp_out for every nonzero operand.
- Inputs are ignored outside IDLE.

Optional Feature:
NORM_FLUSH_EN
- Defined: any result that would assert denorm is flushed instead: mantis_out=0, exp_out=0, zero=1, denorm=0. shift_total still reports the shift applied. Latency is unchanged.
- Undefined: denormal results pass through as described above, with denorm=1.

Test Plan:
- Already normalised: exp_in=8'd100, mantis_in=26'h2000000 -> out_valid 1 cycle after accept; exp_out=100, mantis_out=26'h2000000, shift_total=0, zero=0, denorm=0.
- Deep shift: exp_in=100, mantis_in=26'h0000001, STEP=4 (lz=25) -> 7 BUSY cycles; exp_out=75, mantis_out=26'h2000000, shift_total=25.
- Exponent clamp: exp_in=3, mantis_in=26'h0010000 (lz=9) -> exp_out=0, mantis_out=26'h0080000, shift_total=3, denorm=1. With NORM_FLUSH_EN: mantis_out=0, zero=1, denorm=0.
- Zero operand: exp_in=50, mantis_in=0 -> 1 BUSY cycle; exp_out=0, mantis_out=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; on out_ready=1, next cycle in_ready=1 and a new operand is accepted.
- Reset mid-BUSY: assert rst_n=0 during the deep-shift case -> immediate IDLE, out_valid=0, all outputs 0; the next operand processes correctly.

Source files
------------

// File: rtl/normalize_seq.sv
// Multi-cycle mantissa normalizer: left-shifts up to STEP bits per cycle.
// Define NORM_FLUSH_EN to flush denormal results to zero.
module normalize_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 26,
    parameter int STEP  = 4,
    parameter int SH_W  = $clog2(MAN_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [MAN_W-1:0] mantis_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] mantis_out,
    output logic [SH_W-1:0]  shift_total,
    output logic             zero,
    output logic             denorm
);

    localparam int CW = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [MAN_W-1:0] m;
    logic [EXP_W-1:0] e;
    logic [SH_W-1:0]  sh;
    logic             zero_r;
    logic             denorm_r;

    logic [SH_W-1:0]  lz;
    logic [CW-1:0]    s_w;
    logic [SH_W-1:0]  s;
    logic [MAN_W-1:0] m_sh;
    logic [EXP_W-1:0] e_nx;
    logic             m_zero;
    logic             stay;
    logic             accept;
    logic             dn_out;

    // Highest set bit wins, so the scan runs upward
    always_comb begin
        lz = SH_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (m[i]) lz = SH_W'(MAN_W - 1 - i);
        end
    end

    always_comb begin
        s_w = CW'(lz);
        if (CW'(STEP) < s_w) s_w = CW'(STEP);
        if (CW'(e) < s_w) s_w = CW'(e);
        s      = SH_W'(s_w);
        m_sh   = m << s;
        e_nx   = e - EXP_W'(s_w);
        m_zero = (m == '0);
        stay   = (s_w == CW'(STEP));
        dn_out = ~m_sh[MAN_W-1];
        accept = in_valid && (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = BUSY;
            BUSY: if (m_zero || !stay) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        <= '0;
            e        <= '0;
            sh       <= '0;
            zero_r   <= 1'b0;
            denorm_r <= 1'b0;
        end else if (accept) begin
            m        <= mantis_in;
            e        <= exp_in;
            sh       <= '0;
            zero_r   <= 1'b0;
            denorm_r <= 1'b0;
        end else if (state == BUSY) begin
            if (m_zero) begin
                e      <= '0;
                zero_r <= 1'b1;
            end else begin
                m  <= m_sh;
                e  <= e_nx;
                sh <= sh + s;
                if (!stay && dn_out) begin
`ifdef NORM_FLUSH_EN
                    m      <= '0;
                    e      <= '0;
                    zero_r <= 1'b1;
`else
                    denorm_r <= 1'b1;
`endif
                end
            end
        end
    end

    assign exp_out     = e;
    assign mantis_out  = m;
    assign shift_total = sh;
    assign zero        = zero_r;
    assign denorm      = denorm_r;

endmodule

// File: tb/tb_normalize_seq.sv
// Directed self-checking bench for normalize_seq (default parameters).
// Expectations follow NORM_FLUSH_EN when that macro is defined.
module tb_normalize_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_in;
    logic [25:0] mantis_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [25:0] mantis_out;
    logic [5:0]  shift_total;
    logic        zero;
    logic        denorm;

    int checks = 0;
    int errors = 0;

    normalize_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_in(exp_in), .mantis_in(mantis_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .mantis_out(mantis_out),
        .shift_total(shift_total), .zero(zero), .denorm(denorm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Accept one operand, return BUSY cycles until out_valid
    task automatic launch(input logic [7:0] e, input logic [25:0] m,
                          output int cyc);
        @(negedge clk);
        check("launch_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        exp_in    = e;
        mantis_in = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("timeout", out_valid, 1'b1);
    endtask

    task automatic result(input string tag, input int cyc, input int ecyc,
                          input logic [7:0] ee, input logic [25:0] em,
                          input logic [5:0] es, input logic ez,
                          input logic ed);
        check({tag, "_lat"}, cyc, ecyc);
        check({tag, "_exp"}, exp_out, ee);
        check({tag, "_man"}, mantis_out, em);
        check({tag, "_sh"}, shift_total, es);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_dn"}, denorm, ed);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("ret_ready", in_ready, 1'b1);
        check("ret_valid", out_valid, 1'b0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_in    = '0;
        mantis_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_exp", exp_out, 8'd0);
        check("rst_man", mantis_out, 26'd0);
        check("rst_sh", shift_total, 6'd0);
        check("rst_zero", zero, 1'b0);
        check("rst_dn", denorm, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(8'd100, 26'h2000000, cyc);
        result("norm", cyc, 1, 8'd100, 26'h2000000, 6'd0, 1'b0, 1'b0);
        consume();

        // Deep shift, then hold backpressure for 5 cycles
        launch(8'd100, 26'h0000001, cyc);
        result("deep", cyc, 7, 8'd75, 26'h2000000, 6'd25, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1'b1);
            check("bp_ready", in_ready, 1'b0);
            check("bp_exp", exp_out, 8'd75);
            check("bp_man", mantis_out, 26'h2000000);
        end
        consume();

        launch(8'd3, 26'h0010000, cyc);
`ifdef NORM_FLUSH_EN
        result("clamp", cyc, 1, 8'd0, 26'h0, 6'd3, 1'b1, 1'b0);
`else
        result("clamp", cyc, 1, 8'd0, 26'h0080000, 6'd3, 1'b0, 1'b1);
`endif
        consume();

        launch(8'd50, 26'h0, cyc);
        result("zero", cyc, 1, 8'd0, 26'h0, 6'd0, 1'b1, 1'b0);
        consume();

        // Exponent already 0: pass-through with denorm rule
        launch(8'd0, 26'h0000100, cyc);
`ifdef NORM_FLUSH_EN
        result("e0", cyc, 1, 8'd0, 26'h0, 6'd0, 1'b1, 1'b0);
`else
        result("e0", cyc, 1, 8'd0, 26'h0000100, 6'd0, 1'b0, 1'b1);
`endif
        consume();

        // lz exactly STEP: one extra BUSY cycle
        launch(8'd20, 26'h0200000, cyc);
        result("lz4", cyc, 2, 8'd16, 26'h2000000, 6'd4, 1'b0, 1'b0);
        consume();

        // Exponent runs out on a full STEP boundary
        launch(8'd4, 26'h0000001, cyc);
`ifdef NORM_FLUSH_EN
        result("eq", cyc, 2, 8'd0, 26'h0, 6'd4, 1'b1, 1'b0);
`else
        result("eq", cyc, 2, 8'd0, 26'h0000010, 6'd4, 1'b0, 1'b1);
`endif
        consume();

        // Reset during deep shift
        @(negedge clk);
        in_valid  = 1'b1;
        exp_in    = 8'd100;
        mantis_in = 26'h0000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_ready", in_ready, 1'b1);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_exp", exp_out, 8'd0);
        check("mrst_man", mantis_out, 26'd0);
        check("mrst_sh", shift_total, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd10, 26'h0400000, cyc);
        result("post", cyc, 1, 8'd7, 26'h2000000, 6'd3, 1'b0, 1'b0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
